// File: rtl/bram_unloader_pkg.sv
// Shared widths and state encoding for the coefficient BRAM read-out stage.
package bram_unloader_pkg;
    localparam int DW = 12;   // coefficient width
    localparam int AW = 6;    // BRAM address width
    localparam int NB = 4;    // number of banks
    localparam int N  = 256;  // coefficients per polynomial
    localparam int IW = 8;    // coefficient index width

    typedef logic [DW-1:0] coef_t;
    typedef logic [NB-1:0][DW-1:0] coef_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/bram_unloader_if.sv
// Coefficient output stream: data, index and last flag under valid/ready.
interface bram_unloader_if;
    logic [bram_unloader_pkg::DW-1:0] m_data;
    logic [bram_unloader_pkg::IW-1:0] m_idx;
    logic                             m_valid;
    logic                             m_ready;
    logic                             m_last;

    modport master (output m_data, output m_idx, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_idx, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_unloader_word_serializer.sv
// Holds one 4-word BRAM row and emits it word by word with index tracking.
module bram_unloader_word_serializer
    import bram_unloader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_valid,
    input  coef_vec_t            b_word,
    output logic                 b_take,
    bram_unloader_if.master      m
);
    coef_vec_t        w_reg;
    logic [1:0]       j_reg;
    logic             w_full_reg;
    logic [IW-1:0]    n_reg;
    logic             hs;

    assign hs = w_full_reg & m.m_ready;
    // Reload on the final word's handshake so the stream never bubbles.
    assign b_take = b_valid & (~w_full_reg | (hs & (j_reg == 2'd3)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg      <= '0;
            j_reg      <= 2'd0;
            w_full_reg <= 1'b0;
            n_reg      <= '0;
        end else begin
            if (b_take) begin
                w_reg      <= b_word;
                w_full_reg <= 1'b1;
            end else if (hs && (j_reg == 2'd3)) begin
                w_full_reg <= 1'b0;
            end
            if (hs) begin
                j_reg <= j_reg + 2'd1;
                n_reg <= n_reg + IW'(1);
            end
        end
    end

    assign m.m_valid = w_full_reg;
    assign m.m_data  = w_reg[j_reg];
    assign m.m_idx   = n_reg;
    assign m.m_last  = w_full_reg & (n_reg == IW'(N - 1));
endmodule

// File: rtl/bram_unloader.sv
// Reads four 64x12 coefficient banks row by row and streams 256 coefficients
// in natural order, one per cycle under full backpressure.
module bram_unloader
    import bram_unloader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   raddr,
    input  logic [DW-1:0]   dout0,
    input  logic [DW-1:0]   dout1,
    input  logic [DW-1:0]   dout2,
    input  logic [DW-1:0]   dout3,
    bram_unloader_if.master m
);
    state_t          state_reg, state_next;
    logic [AW:0]     addr_reg;
    logic [AW-1:0]   raddr_reg;
    logic            rd_pend_reg;
    logic            b_full_reg;
    coef_vec_t       b_data_reg;
    coef_vec_t       dout_vec;
    coef_vec_t       b_word;
    logic            b_valid;
    logic            b_take;
    logic            issue;
    logic            last_hs;

    assign dout_vec[0] = dout0;
    assign dout_vec[1] = dout1;
    assign dout_vec[2] = dout2;
    assign dout_vec[3] = dout3;

    // While a read is in flight, B is presented straight from the BRAM outputs
    // so a row can reach W the same cycle it arrives.
    assign b_valid = b_full_reg | rd_pend_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            assign b_word[gi] = rd_pend_reg ? dout_vec[gi] : b_data_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    b_data_reg[gi] <= '0;
                else if (rd_pend_reg && !b_take)
                    b_data_reg[gi] <= dout_vec[gi];
            end
        end
    endgenerate

    assign issue   = (state_reg == ST_RUN) && !addr_reg[AW] && !b_full_reg && !rd_pend_reg;
    assign raddr   = issue ? addr_reg[AW-1:0] : raddr_reg;
    assign last_hs = m.m_valid & m.m_ready & m.m_last;
    assign busy    = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)   state_next = ST_RUN;
            ST_RUN:  if (last_hs) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            raddr_reg   <= '0;
            rd_pend_reg <= 1'b0;
            b_full_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= issue;
            if (state_reg == ST_IDLE && start)
                addr_reg <= '0;
            else if (issue)
                addr_reg <= addr_reg + (AW+1)'(1);
            if (issue)
                raddr_reg <= addr_reg[AW-1:0];
            if (b_take)
                b_full_reg <= 1'b0;
            else if (rd_pend_reg)
                b_full_reg <= 1'b1;
        end
    end

    bram_unloader_word_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .b_valid (b_valid),
        .b_word  (b_word),
        .b_take  (b_take),
        .m       (m)
    );
endmodule

// File: tb/tb_bram_unloader.sv
// Directed bench for bram_unloader: BRAM model, cycle-accurate vector table
// for latency/backpressure, and streamed full runs against n*13 mod 3329.
module tb_bram_unloader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [5:0]  raddr;
    logic [11:0] dout [4];
    logic [11:0] mem [4][64];

    int vec_cnt = 0;
    int err_cnt = 0;

    bram_unloader_if ui();

    bram_unloader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .raddr (raddr),
        .dout0 (dout[0]),
        .dout1 (dout[1]),
        .dout2 (dout[2]),
        .dout3 (dout[3]),
        .m     (ui)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) dout[b] <= mem[b][raddr];
    end

    function automatic int exp_coef(input int n);
        return (n * 13) % 3329;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    typedef struct {
        bit rdy;
        int raddr;
        bit valid;
        int idx;
        bit busy;
    } vec_t;

    task automatic do_start(input bit rdy);
        @(negedge clk);
        start = 1'b1;
        ui.m_ready = rdy;
        #1;
    endtask

    // mode 0: ready=1, 1: random, 2: toggling. stop_n >= 0 returns early.
    task automatic stream(input int n0, input int mode, input int stop_n, input bit inject);
        int   n_exp = n0;
        bit   pv = 0, pr = 0, pl = 0, last_prev = 0, injected = 0, fin = 0, hs;
        int   pd = 0, pi = 0, done_cnt = 0, post = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            case (mode)
                0:       ui.m_ready = 1'b1;
                1:       ui.m_ready = 1'($urandom_range(0, 1));
                default: ui.m_ready = ~ui.m_ready;
            endcase
            start = last_prev;
            if (inject && !injected && n_exp == 100) begin
                start = 1'b1;
                injected = 1;
            end
            #1;
            if (pv && !pr) begin
                chk("hold_valid", int'(ui.m_valid), 1);
                chk("hold_data", int'(ui.m_data), pd);
                chk("hold_idx", int'(ui.m_idx), pi);
                chk("hold_last", int'(ui.m_last), int'(pl));
            end
            if (last_prev) chk("done_after_last", int'(done), 1);
            if (done) done_cnt++;
            hs = ui.m_valid && ui.m_ready;
            last_prev = 0;
            if (hs) begin
                chk("data", int'(ui.m_data), exp_coef(n_exp));
                chk("idx", int'(ui.m_idx), n_exp);
                chk("last", int'(ui.m_last), int'(n_exp == 255));
                chk("busy_run", int'(busy), 1);
                last_prev = (n_exp == 255);
                n_exp++;
            end
            pv = ui.m_valid; pr = ui.m_ready;
            pd = int'(ui.m_data); pi = int'(ui.m_idx); pl = ui.m_last;
            if (stop_n >= 0 && n_exp == stop_n) return;
            if (done_cnt > 0) begin
                chk("busy_after_done", int'(busy), 0);
                chk("valid_after_done", int'(ui.m_valid), 0);
                post++;
                if (post == 3) fin = 1;
            end
        end
        start = 1'b0;
        chk("coef_count", n_exp, 256);
        chk("done_count", done_cnt, 1);
    endtask

    vec_t vt [17];

    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                mem[b][a] = 12'(((4 * a + b) * 13) % 3329);

        vt[0]  = '{0, 0, 0, 0, 1};
        vt[1]  = '{0, 0, 0, 0, 1};
        vt[2]  = '{0, 1, 1, 0, 1};
        vt[3]  = '{0, 1, 1, 0, 1};
        vt[4]  = '{0, 1, 1, 0, 1};
        vt[5]  = '{0, 1, 1, 0, 1};
        vt[6]  = '{0, 1, 1, 0, 1};
        vt[7]  = '{0, 1, 1, 0, 1};
        vt[8]  = '{1, 1, 1, 0, 1};
        vt[9]  = '{1, 1, 1, 1, 1};
        vt[10] = '{1, 1, 1, 2, 1};
        vt[11] = '{1, 1, 1, 3, 1};
        vt[12] = '{1, 2, 1, 4, 1};
        vt[13] = '{1, 2, 1, 5, 1};
        vt[14] = '{1, 2, 1, 6, 1};
        vt[15] = '{1, 2, 1, 7, 1};
        vt[16] = '{1, 3, 1, 8, 1};

        ui.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(ui.m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(ui.m_data), 0);
        chk("rst_idx", int'(ui.m_idx), 0);
        chk("rst_last", int'(ui.m_last), 0);
        chk("rst_raddr", int'(raddr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and backpressure: start with m_ready=0, hold, then release.
        do_start(1'b0);
        chk("c0_busy", int'(busy), 0);
        for (int i = 0; i < 17; i++) begin
            if (i == 8) begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    start = 1'b0;
                    ui.m_ready = 1'b0;
                    #1;
                    chk("stall_raddr", int'(raddr), 1);
                    chk("stall_idx", int'(ui.m_idx), 0);
                end
            end
            @(negedge clk);
            start = 1'b0;
            ui.m_ready = vt[i].rdy;
            #1;
            chk($sformatf("v%0d_raddr", i), int'(raddr), vt[i].raddr);
            chk($sformatf("v%0d_valid", i), int'(ui.m_valid), int'(vt[i].valid));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vt[i].busy));
            if (vt[i].valid) begin
                chk($sformatf("v%0d_idx", i), int'(ui.m_idx), vt[i].idx);
                chk($sformatf("v%0d_data", i), int'(ui.m_data), exp_coef(vt[i].idx));
            end
            $display("vec %0d: rdy=%0d raddr=%0d valid=%0d idx=%0d data=%0d",
                     i, vt[i].rdy, raddr, ui.m_valid, ui.m_idx, ui.m_data);
        end
        stream(9, 0, -1, 0);
        $display("run backpressure-release complete");

        do_start(1'b1);
        stream(0, 0, -1, 0);
        $display("run ready=1 complete");

        do_start(1'b1);
        stream(0, 1, -1, 0);
        $display("run random-ready complete");

        do_start(1'b0);
        stream(0, 2, -1, 1);
        $display("run toggle-ready with restart pulse complete");

        do_start(1'b1);
        stream(0, 1, 50, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(ui.m_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset at n=50 applied");
        do_start(1'b1);
        stream(0, 0, -1, 0);
        $display("run after reset complete");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/bram_unloader.md
Name: bram_unloader

Overview:
- Downstream read-out stage for the four 64x12 coefficient BRAMs of a pe4 polynomial multiplier; 1 cc read latency.
- On `start`, drives one shared read address to all four banks and captures the four 12-bit words one cycle later.
- Serializes the 256 coefficients in natural order (n = 4*addr + bank) onto a valid/ready stream, with full backpressure, at 1 coefficient/cycle sustained.

Parameters:
- DW, 12, coefficient width (q = 3329 fits).
- AW, 6, BRAM address width (64 words per bank).
- NB, 4, number of banks; fixed at 4 in this revision.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts read-out; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, the cycle after the final output handshake.
- raddr  out  AW  shared read address to all four BRAMs.
- dout0..dout3  in  DW each  BRAM read data, bank j, valid 1 cc after raddr.
- m_data  out  DW  output coefficient.
- m_idx  out  8  coefficient index n of m_data.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with m_valid when m_idx = 255.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, m_idx=0, raddr=0; all buffers empty; rd_pend=0. Reset mid-run aborts the run; no done is issued.
- FSM states:
  - IDLE: start=1 -> RUN, with a=0, n=0.
  - RUN: last handshake (m_valid & m_ready & m_last) -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Handshake: a transfer occurs on a cycle with m_valid & m_ready.
- Read issue (RUN): a read is issued in cycle t when a<64, B is empty, and rd_pend=0.
  - raddr=a in t; rd_pend=1; a increments.
  - In t+1, B <= {dout3,dout2,dout1,dout0}; rd_pend=0.
  - raddr holds its last value when no read is issued.
- Holding register W (4 words, word pointer j 0..3, W_full flag): W <= B and B empties, when B is full and either (W empty) or (handshake on j=3).
- Output:
  - m_valid = W_full; m_data = W[j]; m_idx = n; m_last = (n=255).
  - On handshake: j increments and n increments; when j=3, W empties unless reloaded the same cycle.
- Stability: while m_valid=1 and m_ready=0, m_data, m_idx and m_last are held stable.
- Latency: first m_valid 3 cycles after the start pulse (start -> raddr=0 -> B -> W).
- Throughput: with m_ready held at 1, 256 consecutive valid cycles with no bubbles. B is always refilled within 2 cycles, and W takes 4 cycles to drain.
- Boundaries:
  - n wraps to 0 on completion.
  - Once a=64, no further reads are issued.
  - start asserted together with done, or during RUN, is ignored.
  - m_ready toggling every cycle loses and duplicates no word.

Decomposition:
- Shared package: DW, AW, NB, N=256, state encoding IDLE/RUN/DONE.
- One natural sub-module: word_serializer, which holds W, j, W_full, the load/shift logic and the m_* outputs. The top level keeps the FSM, address counter, rd_pend and buffer B.

Test Plan:
- Preload bank j, addr a with value (4a+j)*13 mod 3329; start with m_ready=1. Expect m_data at n equal to n*13 mod 3329, and m_idx = 0..255 on 256 consecutive cycles. m_last is 1 only at n=255; done pulses once, 1 cycle after the n=255 handshake.
- Same data, m_ready pseudo-random (50%). Expect the identical 256-value sequence, with m_data held stable whenever m_valid=1 and m_ready=0.
- m_ready=0 for 20 cycles after start. Expect raddr to stop at 1 (only addr 0 and 1 read): W holds n=0..3, B holds n=4..7. Release m_ready: expect n=0 out first with no loss.
- Pulse start again at n=100. Expect the sequence unaffected, busy=1 throughout, and exactly one done.
- Assert rst_n=0 at n=50. Expect m_valid=0, busy=0 and done=0 immediately (async). A new start then yields n=0..255 from the beginning.
- Check the latency: a start pulse at cycle 0 gives raddr=0 at cycle 1 and the first m_valid at cycle 3, with m_data=0 and m_idx=0.
